// File: rtl/if_stage_sram_if.sv
// Fetch-stage bundle: ID redirect/handshake and the instruction SRAM
// request/response channel.
interface if_stage_sram_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  id_allow_in,
        output if_to_id_valid,
        output if_to_id_pc,
        output if_to_id_inst,
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        output id_allow_in,
        input  if_to_id_valid,
        input  if_to_id_pc,
        input  if_to_id_inst,
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_stage_sram.sv
// Instruction fetch over a request/response SRAM port, with an in-order
// return queue and flush-by-drop-count on ID redirects.
module if_stage_sram #(
    parameter logic [31:0] RESET_PC  = 32'hbfc00000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    if_stage_sram_if.master bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH = cnt_t'(BUF_DEPTH);

    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [31:0]          pc_q   [BUF_DEPTH];
    logic [31:0]          pc_d   [BUF_DEPTH];
    logic [31:0]          inst_q [BUF_DEPTH];
    logic [31:0]          inst_d [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] done_q, done_d;
    ptr_t                 head_q, head_d;
    ptr_t                 tail_q, tail_d;
    cnt_t                 used_q, used_d;
    cnt_t                 drop_q, drop_d;

    cnt_t pend;
    ptr_t ret;
    logic room;
    logic req;
    logic hs;
    logic valid;
    logic pop;
    logic drop_hit;
    logic fill;
    logic consumed;

    // Count queued entries still waiting for their instruction word.
    always_comb begin
        pend = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (cnt_t'(i) < used_q && !done_q[head_q + ptr_t'(i)]) begin
                pend = pend + cnt_t'(1);
            end
        end
    end

    // Returns are in order, so done entries form a prefix from head.
    assign ret      = head_q + ptr_t'(used_q - pend);
    assign room     = ({1'b0, used_q} + {1'b0, drop_q}) < {1'b0, DEPTH};
    assign req      = !reset && !bus.redirect_valid && room;
    assign hs       = req && bus.inst_sram_addr_ok;
    assign valid    = (used_q != '0) && done_q[head_q];
    assign pop      = valid && bus.id_allow_in && !bus.redirect_valid;
    assign drop_hit = bus.inst_sram_data_ok && (drop_q != '0);
    assign fill     = bus.inst_sram_data_ok && (drop_q == '0)
                      && (pend != '0);
    assign consumed = drop_hit || fill;

    // Next state: data return first, then pop and allocate, or flush.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        done_d     = done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        used_d     = used_q;
        drop_d     = drop_q;

        if (drop_hit) begin
            drop_d = drop_q - cnt_t'(1);
        end
        if (fill) begin
            inst_d[ret] = bus.inst_sram_rdata;
            done_d[ret] = 1'b1;
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            drop_d     = drop_q + pend - cnt_t'(consumed);
            head_d     = '0;
            tail_d     = '0;
            used_d     = '0;
            done_d     = '0;
        end else begin
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            if (hs) begin
                pc_d[tail_q]   = fetch_pc_q;
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + ptr_t'(1);
                fetch_pc_d     = fetch_pc_q + 32'd4;
            end
            used_d = used_q + cnt_t'(hs) - cnt_t'(pop);
        end
    end

    // Control state, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            used_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            used_q     <= used_d;
            drop_q     <= drop_d;
        end
    end

    // Payload storage; only meaningful where the control state says so.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = fetch_pc_q;
    assign bus.if_to_id_valid = valid;
    assign bus.if_to_id_pc    = (used_q != '0) ? pc_q[head_q] : '0;
    assign bus.if_to_id_inst  = (used_q != '0) ? inst_q[head_q] : '0;
endmodule

// File: tb/tb_if_stage_sram.sv
// Bench for if_stage_sram: directed scenarios plus a randomized run
// against a program-order fetch model and an SRAM response queue.
module tb_if_stage_sram;
    localparam logic [31:0] RPC = 32'hbfc00000;
    localparam int          D   = 4;

    logic clk = 1'b0;
    logic reset;

    if_stage_sram_if bus ();

    if_stage_sram #(
        .RESET_PC (RPC),
        .BUF_DEPTH(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
    } ent_t;

    ent_t        q[$];
    int          m_buf;
    int          m_ep;
    logic [31:0] m_fetch;
    logic [31:0] m_exp;
    int          checks;
    int          errors;
    bit          rnd;
    int          p_addr;
    int          p_data;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic model_clear();
        q.delete();
        m_buf   = 0;
        m_fetch = RPC;
        m_exp   = RPC;
    endtask

    task automatic drive_sram();
        if (rnd) begin
            bus.inst_sram_addr_ok = ($urandom_range(99) < 32'(p_addr));
            bus.inst_sram_data_ok = (q.size() > 0)
                && ($urandom_range(99) < 32'(p_data));
        end
        bus.inst_sram_rdata = (q.size() > 0) ? word(q[0].addr)
                                             : 32'hdeadbeef;
    endtask

    // Advance the model by the current cycle, then move to the next one.
    task automatic tick();
        bit   hs;
        bit   mv;
        ent_t e;
        if (!reset) begin
            hs = bus.inst_sram_req && bus.inst_sram_addr_ok;
            mv = (m_buf > 0);
            if (bus.inst_sram_data_ok && q.size() > 0) begin
                e = q.pop_front();
                if (e.ep == m_ep) m_buf++;
            end
            if (hs) q.push_back('{addr: bus.inst_sram_addr, ep: m_ep});
            if (bus.redirect_valid) begin
                m_buf   = 0;
                m_ep++;
                m_fetch = bus.redirect_pc;
                m_exp   = bus.redirect_pc;
            end else begin
                if (mv && bus.id_allow_in) begin
                    m_buf--;
                    m_exp += 32'd4;
                end
                if (hs) m_fetch += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        drive_sram();
        #1;
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        rnd                   = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.id_allow_in       = 1'b0;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        drive_sram();
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b want 0", bus.inst_sram_req);
        end
        checks++;
        if (bus.if_to_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.if_to_id_valid);
        end
        checks++;
        if (bus.if_to_id_pc !== 32'h0 || bus.if_to_id_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_inst got %h/%h want 0/0",
                     bus.if_to_id_pc, bus.if_to_id_inst);
        end
        reset = 1'b0;
        model_clear();
        bus.inst_sram_addr_ok = 1'b1;
        bus.id_allow_in       = 1'b1;
        drive_sram();
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RPC) begin
            errors++;
            $display("FAIL first_req got %b/%h want 1/%h",
                     bus.inst_sram_req, bus.inst_sram_addr, RPC);
        end
    endtask

    task automatic test_latency();
        logic [31:0] want;
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.inst_sram_addr_ok = 1'b1;
            bus.inst_sram_data_ok = (q.size() > 0);
            #1;
            checks++;
            if (bus.if_to_id_valid !== (k >= 2)) begin
                errors++;
                $display("FAIL latency_valid c%0d got %b want %b",
                         k, bus.if_to_id_valid, (k >= 2));
            end
            if (k >= 2) begin
                want = RPC + 32'(4 * (k - 2));
                checks++;
                if (bus.if_to_id_pc !== want
                    || bus.if_to_id_inst !== word(want)) begin
                    errors++;
                    $display("FAIL latency_pc c%0d got %h/%h want %h/%h",
                             k, bus.if_to_id_pc, bus.if_to_id_inst,
                             want, word(want));
                end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        int          n;
        logic [31:0] want;
        do_reset();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            bus.inst_sram_addr_ok = 1'b1;
            bus.inst_sram_data_ok = (q.size() > 0);
            #1;
            if (bus.inst_sram_req && bus.inst_sram_addr_ok) n++;
            tick();
        end
        checks++;
        if (n != D) begin
            errors++;
            $display("FAIL stall_handshakes got %0d want %0d", n, D);
        end
        bus.inst_sram_addr_ok = 1'b1;
        bus.inst_sram_data_ok = (q.size() > 0);
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req got %b want 0", bus.inst_sram_req);
        end
        checks++;
        if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== RPC) begin
            errors++;
            $display("FAIL stall_head got %b/%h want 1/%h",
                     bus.if_to_id_valid, bus.if_to_id_pc, RPC);
        end
        for (int j = 0; j < 4; j++) begin
            bus.inst_sram_addr_ok = 1'b1;
            bus.inst_sram_data_ok = (q.size() > 0);
            bus.id_allow_in       = 1'b1;
            #1;
            want = RPC + 32'(4 * j);
            checks++;
            if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== want) begin
                errors++;
                $display("FAIL stall_drain j%0d got %b/%h want 1/%h",
                         j, bus.if_to_id_valid, bus.if_to_id_pc, want);
            end
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] tgt;
        tgt = 32'hbfc00100;
        do_reset();
        bus.id_allow_in = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            bus.inst_sram_addr_ok = (c <= 5) || (c == 7);
            bus.inst_sram_data_ok = (c >= 1 && c <= 4) || (c >= 7 && c <= 9);
            bus.redirect_valid    = (c == 6);
            bus.redirect_pc       = tgt;
            #1;
            if (c == 6) begin
                checks++;
                if (bus.inst_sram_req !== 1'b0 || bus.if_to_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_redirect_cycle got req %b valid %b want 0 0",
                             bus.inst_sram_req, bus.if_to_id_valid);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== tgt) begin
                    errors++;
                    $display("FAIL drop_new_req got %b/%h want 1/%h",
                             bus.inst_sram_req, bus.inst_sram_addr, tgt);
                end
            end
            if (c >= 7 && c <= 9) begin
                checks++;
                if (bus.if_to_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_stale c%0d got valid %b pc %h want 0",
                             c, bus.if_to_id_valid, bus.if_to_id_pc);
                end
            end
            if (c == 10) begin
                checks++;
                if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== tgt
                    || bus.if_to_id_inst !== word(tgt)) begin
                    errors++;
                    $display("FAIL drop_target got %b/%h/%h want 1/%h/%h",
                             bus.if_to_id_valid, bus.if_to_id_pc,
                             bus.if_to_id_inst, tgt, word(tgt));
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] tgt;
        tgt = 32'hbfc00200;
        do_reset();
        bus.id_allow_in = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            bus.inst_sram_addr_ok = (c <= 2) || (c == 4);
            bus.inst_sram_data_ok = (c >= 3 && c <= 6);
            bus.redirect_valid    = (c == 3);
            bus.redirect_pc       = tgt;
            #1;
            if (c == 3) begin
                checks++;
                if (bus.inst_sram_req !== 1'b0 || bus.if_to_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL same_redirect_cycle got req %b valid %b want 0 0",
                             bus.inst_sram_req, bus.if_to_id_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== tgt) begin
                    errors++;
                    $display("FAIL same_new_req got %b/%h want 1/%h",
                             bus.inst_sram_req, bus.inst_sram_addr, tgt);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (bus.if_to_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL same_stale c%0d got valid %b pc %h want 0",
                             c, bus.if_to_id_valid, bus.if_to_id_pc);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== tgt
                    || bus.if_to_id_inst !== word(tgt)) begin
                    errors++;
                    $display("FAIL same_target got %b/%h/%h want 1/%h/%h",
                             bus.if_to_id_valid, bus.if_to_id_pc,
                             bus.if_to_id_inst, tgt, word(tgt));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rnd             = 1'b1;
        p_addr          = 100;
        p_data          = 100;
        bus.id_allow_in = 1'b1;
        drive_sram();
        #1;
        repeat (6) tick();
        checks++;
        if (bus.if_to_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_valid got %b want 1", bus.if_to_id_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b0 || bus.if_to_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate got req %b valid %b want 0 0",
                     bus.inst_sram_req, bus.if_to_id_valid);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        drive_sram();
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RPC) begin
            errors++;
            $display("FAIL areset_restart got %b/%h want 1/%h",
                     bus.inst_sram_req, bus.inst_sram_addr, RPC);
        end
        tick();
        tick();
        checks++;
        if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== RPC) begin
            errors++;
            $display("FAIL areset_first_inst got %b/%h want 1/%h",
                     bus.if_to_id_valid, bus.if_to_id_pc, RPC);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.id_allow_in = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            bus.redirect_valid    = (c == 0);
            bus.redirect_pc       = 32'hfffffff8;
            bus.inst_sram_addr_ok = (c == 1) || (c == 2);
            bus.inst_sram_data_ok = (c == 3) || (c == 4);
            #1;
            if (c == 0) begin
                checks++;
                if (bus.inst_sram_req !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_redirect_req got %b want 0",
                             bus.inst_sram_req);
                end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (bus.inst_sram_req !== 1'b1
                    || bus.inst_sram_addr !== 32'hfffffff8 + 32'(4 * (c - 1))) begin
                    errors++;
                    $display("FAIL wrap_addr c%0d got %b/%h want 1/%h", c,
                             bus.inst_sram_req, bus.inst_sram_addr,
                             32'hfffffff8 + 32'(4 * (c - 1)));
                end
            end
            if (c >= 4) begin
                checks++;
                if (bus.if_to_id_valid !== 1'b1
                    || bus.if_to_id_pc !== 32'hfffffff8 + 32'(4 * (c - 4))) begin
                    errors++;
                    $display("FAIL wrap_pc c%0d got %b/%h want 1/%h", c,
                             bus.if_to_id_valid, bus.if_to_id_pc,
                             32'hfffffff8 + 32'(4 * (c - 4)));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit exp_req;
        do_reset();
        rnd    = 1'b1;
        p_addr = 70;
        p_data = 65;
        drive_sram();
        for (int n = 0; n < 1500; n++) begin
            bus.id_allow_in    = ($urandom_range(99) < 75);
            bus.redirect_valid = ($urandom_range(99) < 5);
            if ($urandom_range(99) < 25)
                bus.redirect_pc = 32'hfffffff0 + {$urandom_range(3), 2'b00};
            else
                bus.redirect_pc = $urandom & 32'hfffffffc;
            #1;
            exp_req = !bus.redirect_valid && (q.size() + m_buf < D);
            checks++;
            if (bus.inst_sram_req !== exp_req) begin
                errors++;
                $display("FAIL rand_req n%0d got %b want %b",
                         n, bus.inst_sram_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (bus.inst_sram_addr !== m_fetch) begin
                    errors++;
                    $display("FAIL rand_addr n%0d got %h want %h",
                             n, bus.inst_sram_addr, m_fetch);
                end
            end
            checks++;
            if (bus.if_to_id_valid !== (m_buf > 0)) begin
                errors++;
                $display("FAIL rand_valid n%0d got %b want %b",
                         n, bus.if_to_id_valid, (m_buf > 0));
            end
            if (m_buf > 0) begin
                checks++;
                if (bus.if_to_id_pc !== m_exp
                    || bus.if_to_id_inst !== word(m_exp)) begin
                    errors++;
                    $display("FAIL rand_head n%0d got %h/%h want %h/%h", n,
                             bus.if_to_id_pc, bus.if_to_id_inst,
                             m_exp, word(m_exp));
                end
            end
            tick();
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        rnd                   = 1'b0;
        p_addr                = 100;
        p_data                = 100;
        m_ep                  = 0;
        reset                 = 1'b1;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = 32'h0;
        bus.id_allow_in       = 1'b0;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'h0;
        model_clear();
        test_reset();
        test_latency();
        test_full_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage_sram.md
# if_stage_sram

Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. It replaces the single-cycle synchronous-RAM fetch with a request/response SRAM-like interface that can keep several requests outstanding. It buffers returned instructions with their PCs in an in-order queue of configurable depth. On a redirect from ID it flushes all buffered and in-flight fetches, and it presents instructions to ID with the standard valid/allow_in handshake.

## Interface
- RESET_PC, 32'hbfc00000, PC of the first fetched instruction.
- BUF_DEPTH, 4, queue entries; power of two, 2..16. It also bounds the number of outstanding requests.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset. Assertion clears all state immediately; release is sampled on clk.
- redirect_valid  in  1  ID has resolved a taken branch, jump or jr.
- redirect_pc  in  32  target PC; valid while redirect_valid=1.
- id_allow_in  in  1  ID accepts an instruction this cycle.
- if_to_id_valid  out  1  queue head holds a returned instruction.
- if_to_id_pc  out  32  PC of the head instruction.
- if_to_id_inst  out  32  instruction word of the head.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address, equal to fetch_pc.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  oldest accepted request returns data this cycle.
- inst_sram_rdata  in  32  returned instruction word.

## Operation
- State:
  - fetch_pc register.
  - Circular queue of BUF_DEPTH entries {pc, inst, done}, with head/tail pointers.
  - used count, width clog2(BUF_DEPTH)+1.
  - drop count, same width.
- Reset values: fetch_pc=RESET_PC; queue empty; drop=0; inst_sram_req=0; if_to_id_valid=0. if_to_id_pc and if_to_id_inst are 0 while the queue is empty.
- inst_sram_req = !reset && !redirect_valid && (used + drop < BUF_DEPTH). It is combinational from registers and redirect_valid.
- Address handshake (req && addr_ok):
  - Allocate the tail entry with pc=fetch_pc and done=0.
  - Advance tail, increment used.
  - fetch_pc += 4, with 32-bit wrap (32'hfffffffc+4 = 0).
- Data return (data_ok):
  - If drop>0: decrement drop and discard rdata.
  - Otherwise: write rdata into the oldest entry with done=0 and set done.
  - If used=0 and drop=0, data_ok is a protocol error and is ignored.
- Output:
  - if_to_id_valid = used>0 && head.done.
  - Pop on if_to_id_valid && id_allow_in: advance head, decrement used.
- Redirect (redirect_valid=1):
  - Set fetch_pc=redirect_pc.
  - Set drop = drop + (number of entries with done=0), counted before this cycle's data_ok. A data_ok arriving in the same cycle is consumed against the old state first.
  - Empty the queue and suppress the pop.
  - ID asserts redirect only after it has taken the delay-slot instruction, so the flush never loses a delay slot.
- Simultaneous events in one cycle: apply data_ok, then pop, then allocate. used changes by at most +1-1. Redirect overrides pop and allocate. No handshake can occur during redirect because req=0.
- Full: when used + drop = BUF_DEPTH, req=0 and fetch_pc holds.
- Asserting reset mid-operation abandons all in-flight requests. The SRAM side is reset by the same signal.

## Timing
- First req is in the first cycle after reset release, with addr=RESET_PC.
- Minimum latency:
  - addr_ok in cycle N, data_ok in N+1.
  - done is registered, so if_to_id_valid=1 in N+2.
- Throughput is 1 instruction per cycle when addr_ok and data_ok are held at 1 and id_allow_in=1.
- A redirect in cycle N produces req with addr=redirect_pc in N+1. No stale instruction is presented in or after N+1.
- Outputs depend only on registers, except inst_sram_req, which also depends on redirect_valid.

## Test plan
- Reset, then SRAM with 1-cycle data latency and id_allow_in=1 -> PCs bfc00000, bfc00004, bfc00008 are presented on consecutive cycles, the first two cycles after the first addr_ok.
- id_allow_in=0 with BUF_DEPTH=4 and the SRAM always ready -> exactly 4 handshakes, then req=0. if_to_id_pc holds at bfc00000. Releasing id_allow_in drains the queue in order.
- Two requests outstanding (bfc00010, bfc00014), then redirect to bfc00100 -> drop=2. Both returned words are discarded, and the next instruction presented has pc=bfc00100.
- data_ok in the same cycle as redirect, with 3 outstanding -> the first return is consumed, drop=2, and no stale instruction is presented.
- Reset asserted mid-stream, asynchronously between clock edges -> if_to_id_valid and req fall immediately. After release, fetch restarts at bfc00000.
- fetch_pc=fffffffc, handshake -> next addr=00000000.
